wqi_acq_sequencer: RTL and testbench

- Sequences one water-quality measurement cycle end to end.
- Fetches the six normalised sensor values (pH, Ca, Mg, Ir, Fl, TB) from a shared, time-multiplexed sensor/ADC bus using a REQ/ACK handshake.
- Presents all six values atomically to the WQI datapath, then waits a fixed settle time for the WQI arithmetic and the fuzzification, rulebase and defuzzification stages.
- Captures the WQI value, PWM duty and exception flags, and reports completion.
- Sits between the sensor front end and the WQI/fuzzy/PWM chain; runs on single-shot START or a periodic auto trigger.

---
 rtl/wqi_pkg.sv | 31 +++
 rtl/wqi_period_timer.sv | 43 ++++
 rtl/wqi_acq_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_wqi_acq_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wqi_pkg.sv
// -----------------------------------------------------------------------------
// wqi_pkg
// Shared definitions for the water-quality acquisition slice.
//   - Sensor channel indices as seen on SENS_CH, and the channel count.
//   - Sequencer state encoding.
//   - Bit positions inside the {Exception, Overflow, Underflow} flag vector.
// -----------------------------------------------------------------------------
package wqi_pkg;

    localparam int NUM_CH = 6;

    localparam logic [2:0] CH_PH = 3'd0;
    localparam logic [2:0] CH_CA = 3'd1;
    localparam logic [2:0] CH_MG = 3'd2;
    localparam logic [2:0] CH_IR = 3'd3;
    localparam logic [2:0] CH_FL = 3'd4;
    localparam logic [2:0] CH_TB = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_GAP,
        ST_SETTLE,
        ST_DONE
    } state_t;

    localparam int EXC_UNDERFLOW = 0;
    localparam int EXC_OVERFLOW  = 1;
    localparam int EXC_EXCEPTION = 2;

endpackage

// File: rtl/wqi_period_timer.sv
// -----------------------------------------------------------------------------
// wqi_period_timer
// Free-running auto-trigger counter. While EN is high it counts 0..PERIOD-1
// and raises TICK for the single cycle in which it sits at PERIOD-1, then
// wraps to 0. Dropping EN returns the counter to 0, so re-enabling always
// gives a full period before the first tick.
//
// Ports:
//   CLK    in   system clock, rising edge
//   RESET  in   asynchronous, active-high reset
//   EN     in   count enable (AUTO_EN)
//   TICK   out  one-cycle trigger pulse
// -----------------------------------------------------------------------------
module wqi_period_timer #(
    parameter int unsigned SAMPLE_PERIOD = 100000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic EN,
    output logic TICK
);

    localparam int CNT_W = $clog2(SAMPLE_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: state registers take the asynchronous reset in the sensitivity
    // list and are only ever updated with non-blocking assignments, so every
    // flop samples the pre-edge values of its neighbours.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt <= '0;
        end else if (!EN || cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign TICK = EN && (cnt == CNT_LAST);

endmodule

// File: rtl/wqi_acq_sequencer.sv
// -----------------------------------------------------------------------------
// wqi_acq_sequencer
// Runs one water-quality measurement cycle: reads the six normalised sensor
// values over the shared REQ/ACK sensor bus, presents them together to the
// WQI datapath, waits for the datapath and fuzzy pipeline to settle, then
// captures WQI, duty and exception status and pulses RESULT_VALID.
//
// Ports:
//   CLK, RESET            clock / asynchronous active-high reset
//   START, AUTO_EN        single-shot trigger / periodic trigger enable
//   SENS_REQ, SENS_CH     sensor read request and channel (0=PH .. 5=TB)
//   SENS_ACK, SENS_DATA   sensor data strobe and IEEE-754 sample
//   VN_PH .. VN_TB        registered, atomically updated datapath inputs
//   WQI_IN, DUTY_IN       WQI value and PWM duty from the processing chain
//   EXC_IN                {Exception, Overflow, Underflow}
//   WQI_OUT, DUTY_OUT     captured results
//   RESULT_VALID          one-cycle completion pulse
//   RESULT_ERR            OR of EXC_IN at capture
//   TIMEOUT_ERR           sticky handshake timeout, cleared on next run start
//   BUSY                  high whenever not IDLE
// -----------------------------------------------------------------------------
module wqi_acq_sequencer
    import wqi_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned SAMPLE_PERIOD  = 100000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic        AUTO_EN,
    output logic        SENS_REQ,
    output logic [2:0]  SENS_CH,
    input  logic        SENS_ACK,
    input  logic [31:0] SENS_DATA,
    output logic [31:0] VN_PH,
    output logic [31:0] VN_CA,
    output logic [31:0] VN_MG,
    output logic [31:0] VN_IR,
    output logic [31:0] VN_FL,
    output logic [31:0] VN_TB,
    input  logic [31:0] WQI_IN,
    input  logic [7:0]  DUTY_IN,
    input  logic [2:0]  EXC_IN,
    output logic [31:0] WQI_OUT,
    output logic [7:0]  DUTY_OUT,
    output logic        RESULT_VALID,
    output logic        RESULT_ERR,
    output logic        TIMEOUT_ERR,
    output logic        BUSY
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam int ST_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETTLE_CYCLES - 1);

    state_t          state, state_nxt;
    logic [2:0]      channel;
    logic [TO_W-1:0] to_cnt;
    logic [ST_W-1:0] st_cnt;
    logic            pending;
    logic            tick;
    logic            trigger;
    logic            to_last;
    logic            st_last;

    // Channels 0..4 wait here until TB arrives; TB itself goes straight to
    // VN_TB on the same edge, so it needs no shadow slot.
    logic [31:0]     shadow [NUM_CH-1];

    wqi_period_timer #(
        .SAMPLE_PERIOD (SAMPLE_PERIOD)
    ) u_period_timer (
        .CLK   (CLK),
        .RESET (RESET),
        .EN    (AUTO_EN),
        .TICK  (tick)
    );

    // START and a tick in the same cycle merge into one trigger.
    assign trigger = START | tick;
    assign to_last = (to_cnt == TO_LAST);
    assign st_last = (st_cnt == ST_LAST);
    assign SENS_CH = channel;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal written here gets a default before the case, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt    = state;
        SENS_REQ     = 1'b0;
        BUSY         = 1'b1;
        RESULT_VALID = 1'b0;
        case (state)
            ST_IDLE: begin
                BUSY = 1'b0;
                if (trigger || pending) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                SENS_REQ = 1'b1;
                if (SENS_ACK) begin
                    state_nxt = (channel == CH_TB) ? ST_SETTLE : ST_GAP;
                end else if (to_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_GAP: begin
                state_nxt = ST_REQ;
            end
            ST_SETTLE: begin
                if (st_last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                RESULT_VALID = 1'b1;
                state_nxt    = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            channel     <= CH_PH;
            to_cnt      <= '0;
            st_cnt      <= '0;
            pending     <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
            VN_PH       <= '0;
            VN_CA       <= '0;
            VN_MG       <= '0;
            VN_IR       <= '0;
            VN_FL       <= '0;
            VN_TB       <= '0;
            WQI_OUT     <= '0;
            DUTY_OUT    <= '0;
            RESULT_ERR  <= 1'b0;
            // NOTE: the shadow array is only five words of flops, not a RAM,
            // so it is cleared with everything else to keep reset state fully
            // defined; a real memory would be left out of the reset.
            for (int i = 0; i < NUM_CH - 1; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            // One-deep pending request: set by a trigger that arrives while
            // busy, consumed when IDLE launches the next run.
            if (state == ST_IDLE && state_nxt == ST_REQ) begin
                pending <= 1'b0;
            end else if (trigger && state != ST_IDLE) begin
                pending <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (state_nxt == ST_REQ) begin
                        TIMEOUT_ERR <= 1'b0;
                        channel     <= CH_PH;
                        to_cnt      <= '0;
                    end
                end
                ST_REQ: begin
                    if (SENS_ACK) begin
                        if (channel == CH_TB) begin
                            // All six values reach the datapath on one edge.
                            VN_PH  <= shadow[0];
                            VN_CA  <= shadow[1];
                            VN_MG  <= shadow[2];
                            VN_IR  <= shadow[3];
                            VN_FL  <= shadow[4];
                            VN_TB  <= SENS_DATA;
                            st_cnt <= '0;
                        end else begin
                            shadow[channel] <= SENS_DATA;
                            channel         <= channel + 1'b1;
                        end
                    end else if (to_last) begin
                        // Aborted run: VN_* keep the last complete set.
                        TIMEOUT_ERR <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    to_cnt <= '0;
                end
                ST_SETTLE: begin
                    if (st_last) begin
                        WQI_OUT    <= WQI_IN;
                        DUTY_OUT   <= DUTY_IN;
                        RESULT_ERR <= EXC_IN[EXC_EXCEPTION] | EXC_IN[EXC_OVERFLOW]
                                    | EXC_IN[EXC_UNDERFLOW];
                    end else begin
                        st_cnt <= st_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wqi_acq_sequencer.sv
// -----------------------------------------------------------------------------
// tb_wqi_acq_sequencer
// Directed bench for wqi_acq_sequencer. Stimulus pushes the expected result of
// every run into a scoreboard queue; a negedge monitor pops and compares each
// time RESULT_VALID is seen. Cycle-exact protocol points are checked inline.
// -----------------------------------------------------------------------------
module tb_wqi_acq_sequencer;

    localparam int unsigned SETTLE  = 4;
    localparam int unsigned TIMEOUT = 256;
    localparam int unsigned PERIOD  = 64;

    typedef struct packed {
        logic [31:0]      wqi;
        logic [7:0]       duty;
        logic             err;
        logic [5:0][31:0] vn;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        auto_en = 1'b0;
    logic        sens_req;
    logic [2:0]  sens_ch;
    logic        sens_ack;
    logic [31:0] sens_data;
    logic [31:0] vn_ph, vn_ca, vn_mg, vn_ir, vn_fl, vn_tb;
    logic [31:0] wqi_in = 32'h0;
    logic [7:0]  duty_in = 8'h0;
    logic [2:0]  exc_in = 3'b000;
    logic [31:0] wqi_out;
    logic [7:0]  duty_out;
    logic        result_valid, result_err, timeout_err, busy;

    logic [31:0] data_tbl [6];
    logic [31:0] d1 [6];
    logic [31:0] d2 [6];
    int          withhold_ch = 7;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        sb_q [$];
    logic [5:0][31:0] dut_vn;

    // Sensor front end: acknowledges in the request cycle unless withheld.
    assign sens_ack  = sens_req && (int'(sens_ch) != withhold_ch);
    assign sens_data = (sens_ch < 3'd6) ? data_tbl[sens_ch] : 32'h0;
    assign dut_vn    = {vn_tb, vn_fl, vn_ir, vn_mg, vn_ca, vn_ph};

    wqi_acq_sequencer #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT),
        .SAMPLE_PERIOD  (PERIOD)
    ) dut (
        .CLK          (clk),
        .RESET        (rst),
        .START        (start),
        .AUTO_EN      (auto_en),
        .SENS_REQ     (sens_req),
        .SENS_CH      (sens_ch),
        .SENS_ACK     (sens_ack),
        .SENS_DATA    (sens_data),
        .VN_PH        (vn_ph),
        .VN_CA        (vn_ca),
        .VN_MG        (vn_mg),
        .VN_IR        (vn_ir),
        .VN_FL        (vn_fl),
        .VN_TB        (vn_tb),
        .WQI_IN       (wqi_in),
        .DUTY_IN      (duty_in),
        .EXC_IN       (exc_in),
        .WQI_OUT      (wqi_out),
        .DUTY_OUT     (duty_out),
        .RESULT_VALID (result_valid),
        .RESULT_ERR   (result_err),
        .TIMEOUT_ERR  (timeout_err),
        .BUSY         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp();
        exp_t e;
        e.wqi  = wqi_in;
        e.duty = duty_in;
        e.err  = |exc_in;
        for (int i = 0; i < 6; i++) e.vn[i] = data_tbl[i];
        sb_q.push_back(e);
    endtask

    task automatic wait_valid(input string tag, input int limit);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            if (result_valid) seen = 1'b1;
            else tick();
        end
        check({tag, "_result_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic run_once(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(tag, 100);
        tick();
        check({tag, "_idle_after"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_busy_rise(input string tag, input int limit, output int at);
        logic prev;
        at = -1;
        for (int i = 0; i < limit; i++) begin
            prev = busy;
            tick();
            if (busy && !prev) begin
                at = cyc;
                break;
            end
        end
        check({tag, "_run_started"}, 32'(at >= 0), 32'd1);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && result_valid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_result: RESULT_VALID with no run outstanding, wqi_out=%h (cycle %0d)",
                         wqi_out, cyc);
            end else begin
                e = sb_q.pop_front();
                check("sb_wqi_out", wqi_out, e.wqi);
                check("sb_duty_out", 32'(duty_out), 32'(e.duty));
                check("sb_result_err", 32'(result_err), 32'(e.err));
                for (int i = 0; i < 6; i++) check($sformatf("sb_vn[%0d]", i), dut_vn[i], e.vn[i]);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, n, s1, s2, s3, e0, rises, busy_cycles;
        logic prev;

        d1 = '{32'h40FCCCCD, 32'h425E70A4, 32'h40CF5C29, 32'h3D4CCCCD, 32'h3CA3D70A, 32'h3FA66666};
        d2 = '{32'h41000000, 32'h42000000, 32'h40800000, 32'h3E000000, 32'h3D000000, 32'h3F800000};
        data_tbl = d1;
        wqi_in  = 32'h42A00000;
        duty_in = 8'hC8;
        exc_in  = 3'b000;

        // ---------------- reset state ----------------
        tick(); tick(); tick();
        check("rst_sens_req", 32'(sens_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_vn_ph", vn_ph, 32'd0);
        check("rst_wqi_out", wqi_out, 32'd0);
        check("rst_flags", {28'd0, result_valid, result_err, timeout_err, 1'b0}, 32'd0);
        rst = 1'b0;
        tick(); tick();
        check("idle_busy", 32'(busy), 32'd0);

        // ---------------- cycle-exact nominal run ----------------
        push_exp();
        c0 = cyc;
        start = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            start = 1'b0;
            check($sformatf("t1_sens_req_c%0d", k), 32'(sens_req), 32'((k <= 11) && (k % 2 == 1)));
            if ((k <= 11) && (k % 2 == 1)) check($sformatf("t1_sens_ch_c%0d", k), 32'(sens_ch), 32'((k - 1) / 2));
            check($sformatf("t1_vn_ph_c%0d", k), vn_ph, (k >= 12) ? d1[0] : 32'h0);
            check($sformatf("t1_vn_fl_c%0d", k), vn_fl, (k >= 12) ? d1[4] : 32'h0);
            check($sformatf("t1_result_valid_c%0d", k), 32'(result_valid), 32'(k == 16));
        end
        check("t1_cycle_base", 32'(cyc - c0), 32'd17);
        check("t1_busy_end", 32'(busy), 32'd0);

        // ---------------- handshake timeout on channel 3 ----------------
        data_tbl = d2;
        withhold_ch = 3;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && !(sens_req && sens_ch == 3'd3); i++) tick();
        check("t2_reached_ch3", 32'(sens_req && sens_ch == 3'd3), 32'd1);
        for (int i = 0; i < 400 && sens_req; i++) begin
            n++;
            tick();
        end
        check("t2_req_high_cycles", 32'(n), 32'(TIMEOUT));
        check("t2_timeout_err", 32'(timeout_err), 32'd1);
        check("t2_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 6; i++) check($sformatf("t2_vn_keep[%0d]", i), dut_vn[i], d1[i]);
        tick(); tick();
        check("t2_timeout_sticky", 32'(timeout_err), 32'd1);

        withhold_ch = 7;
        push_exp();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t2_timeout_cleared", 32'(timeout_err), 32'd0);
        wait_valid("t2_recover", 100);
        tick();

        // ---------------- exception flags ----------------
        wqi_in  = 32'h41200000;
        duty_in = 8'h33;
        exc_in  = 3'b010;
        push_exp();
        run_once("t5_exc");
        check("t5_err_held", 32'(result_err), 32'd1);
        wqi_in  = 32'h42C80000;
        duty_in = 8'hF0;
        exc_in  = 3'b000;
        push_exp();
        run_once("t5_clean");

        // ---------------- pending trigger ----------------
        push_exp();
        push_exp();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; tick(); start = 1'b0;      // queued
        tick();
        start = 1'b1; tick(); start = 1'b0;      // dropped
        tick();
        start = 1'b1; tick(); start = 1'b0;      // dropped
        wait_valid("t3_first", 100);
        tick();
        check("t3_idle_gap", 32'(busy), 32'd0);
        tick();
        check("t3_rerun_req", 32'(sens_req), 32'd1);
        check("t3_rerun_ch", 32'(sens_ch), 32'd0);
        wait_valid("t3_second", 100);
        tick();
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy) busy_cycles++;
        end
        check("t3_no_third_run", 32'(busy_cycles), 32'd0);

        // ---------------- periodic trigger ----------------
        for (int i = 0; i < 4; i++) push_exp();
        auto_en = 1'b1;
        e0 = cyc;
        wait_busy_rise("t4_a", 200, s1);
        wait_busy_rise("t4_b", 200, s2);
        wait_busy_rise("t4_c", 200, s3);
        check("t4_first_start", 32'(s1 - e0), 32'(PERIOD));
        check("t4_period_ab", 32'(s2 - s1), 32'(PERIOD));
        check("t4_period_bc", 32'(s3 - s2), 32'(PERIOD));
        for (int i = 0; i < 200 && cyc < s3 + int'(PERIOD) - 1; i++) tick();
        start = 1'b1;                            // coincides with the tick
        tick();
        start = 1'b0;
        auto_en = 1'b0;
        check("t4_coincident_run", 32'(busy), 32'd1);
        rises = 0;
        for (int i = 0; i < 100; i++) begin
            prev = busy;
            tick();
            if (busy && !prev) rises++;
        end
        check("t4_single_run", 32'(rises), 32'd0);

        // ---------------- reset during SETTLE ----------------
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("t6_in_settle_busy", 32'(busy), 32'd1);
        check("t6_vn_loaded", vn_ph, d2[0]);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_sens_req", 32'(sens_req), 32'd0);
        check("t6_async_busy", 32'(busy), 32'd0);
        check("t6_async_vn_ph", vn_ph, 32'd0);
        check("t6_async_vn_tb", vn_tb, 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        check("t6_wqi_cleared", wqi_out, 32'd0);
        check("t6_result_valid", 32'(result_valid), 32'd0);
        data_tbl = d1;
        wqi_in   = 32'h3F800000;
        duty_in  = 8'h01;
        push_exp();
        run_once("t6_after_reset");

        // ---------------- wrap up ----------------
        tick(); tick();
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
